// File: rtl/pll_reset_pkg.sv
// Shared state encoding for the PLL reset sequencer.
package pll_reset_pkg;

    localparam int STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// N-stage flip-flop synchroniser with synchronous clear.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequenced system reset from PLL lock and board button, on the reference clock.
//
// state     | meaning
// HOLD      | reset held for RESET_HOLD_CYCLES
// WAIT_LOCK | waiting for lock with button released
// STABLE    | lock must stay high for LOCK_STABLE_CYCLES
// RUN       | reset released, watching for lock loss
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1200,
    parameter int unsigned CNT_WIDTH          = 16,
    parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      isLocked,
    input  logic                      buttonReset,
    output logic                      resetOut,
    output logic                      systemReady,
    output logic [LOSS_CNT_WIDTH-1:0] lossCount,
    output logic [STATE_WIDTH-1:0]    state
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_MAX = '1;

    logic lock_sync;
    logic button_sync;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_q, loss_d;
    logic                      reset_out_q;
    logic                      ready_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (clk),
        .clr_i (reset),
        .d_i   (isLocked),
        .q_o   (lock_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_button (
        .clk   (clk),
        .clr_i (reset),
        .d_i   (buttonReset),
        .q_o   (button_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        // A lock loss in RUN is counted even when the button fires in the same cycle.
        if (state_q == RUN && !lock_sync && loss_q != LOSS_MAX) begin
            loss_d = loss_q + LOSS_CNT_WIDTH'(1);
        end
        if (button_sync) begin
            state_d = HOLD;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                end
                STABLE: begin
                    if (!lock_sync) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (!lock_sync) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            loss_q      <= '0;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            reset_out_q <= (state_d != RUN);
            // Ready lags the reset release by one cycle but drops with it immediately.
            ready_q     <= !reset_out_q && (state_d == RUN);
        end
    end

    assign resetOut    = reset_out_q;
    assign systemReady = ready_q;
    assign lossCount   = loss_q;
    assign state       = state_q;

endmodule
